// File: rtl/dmem_sram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_sram_resp : byte-lane data SRAM responder with programmable latency.   |
// | Optional range check: define DMEM_RANGE_CHECK_EN.                           |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module dmem_sram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         c_depth    = 1 << DEPTH_LOG2;
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_resp  = 2'd2;
  localparam logic [3:0] c_cnt_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [3:0]            r_wen;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_data_ok;
  logic [31:0]           r_rdata;
  logic                  w_hs;
  logic                  w_resp;
  logic                  w_oor;
  logic                  w_commit;
  logic                  w_unused;
  logic [31:0]           r_mem [0:c_depth-1];

  assign addr_ok  = (r_state == c_st_idle);
  assign w_hs     = req & addr_ok;
  assign w_resp   = (r_state == c_st_resp);
  assign w_commit = w_resp & ~w_oor;
  assign data_ok  = r_data_ok;
  assign rdata    = r_rdata;

`ifdef DMEM_RANGE_CHECK_EN
  logic r_oor;
  logic r_err;

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_oor <= |addr[31:DEPTH_LOG2+2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_resp & r_oor;
    end
  end

  assign w_oor    = r_oor;
  assign err      = r_err;
  assign w_unused = ^addr[1:0];
`else
  // Upper address bits are dropped, so the array aliases modulo its size.
  assign w_oor    = 1'b0;
  assign err      = 1'b0;
  assign w_unused = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_hs) begin
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = c_st_wait;
            w_cnt_nxt   = c_cnt_init;
          end else begin
            w_state_nxt = c_st_resp;
          end
        end
      end
      c_st_wait: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = c_st_resp;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      c_st_resp: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_cnt     <= 4'd0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data_ok <= w_resp;
      if (w_resp) begin
        r_rdata <= w_oor ? 32'd0 : r_mem[r_idx];
      end
    end
  end

  // Request fields are captured only at the handshake; the requester is free afterwards.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_wen   <= wen;
      r_idx   <= addr[DEPTH_LOG2+1:2];
      r_wdata <= wdata;
    end
  end

  // Commit is gated by RESP, which an asynchronous reset clears before the edge.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wen[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_resp.sv
`default_nettype none
// Self-checking bench for dmem_sram_resp: directed table, multi-cycle sequences,
// and randomized traffic against a word-array reference model.
module tb_dmem_sram_resp;

  localparam int DEPTH_LOG2  = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int LAT         = WAIT_CYCLES + 2;
  localparam int DEPTH       = 1 << DEPTH_LOG2;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [int];

  dmem_sram_resp #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge where data_ok is seen.
  task automatic do_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
    logic [31:0] held;
    int n;
    int lat;
    req = 1'b1; wen = w; addr = a; wdata = d;
    n = 0;
    while (addr_ok !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    held = rdata;
    @(posedge clk);
    #1;
    req = 1'b0; wen = 4'($urandom); addr = $urandom; wdata = $urandom;
    @(negedge clk);
    check("pulse_low", 32'(data_ok), 32'd0);
    check("rdata_hold", rdata, held);
    lat = 1;
    while (data_ok !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    check("addr_ok_in_resp", 32'(addr_ok), 32'd1);
    rd = rdata;
    e  = err;
  endtask

  // Request checked against the model: word index, range rule, lane merge.
  task automatic model_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int          idx;
    bit          oor;
    logic [31:0] rd;
    logic        e;
    logic [31:0] nw;
    idx = int'((a >> 2) % DEPTH);
    oor = RC && ((a >> (DEPTH_LOG2 + 2)) != 0);
    do_req(w, a, d, rd, e);
    check("rand_err", 32'(e), 32'(oor));
    if (w == 4'b0000 && (oor || mdl.exists(idx)))
      check("rand_rdata", rd, oor ? 32'd0 : mdl[idx]);
    if (!oor && w != 4'b0000) begin
      if (mdl.exists(idx) || w == 4'hF) begin
        nw = mdl.exists(idx) ? mdl[idx] : 32'd0;
        for (int i = 0; i < 4; i++)
          if (w[i]) nw[8*i +: 8] = d[8*i +: 8];
        mdl[idx] = nw;
      end
    end
  endtask

  function automatic vec_t mk(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                              input bit c, input logic [31:0] x, input logic xe);
    vec_t v;
    v.wen = w; v.addr = a; v.wdata = d; v.chk_rd = c; v.exp_rd = x; v.exp_err = xe;
    return v;
  endfunction

  vec_t        tv [10];
  logic [31:0] rd;
  logic        e;
  int          hs, pulses, c, seen;
  int          ht [3];
  int          pt [3];
  logic [31:0] prd [3];
  bit          take;

  initial begin
    tv[0] = mk(4'hF, 32'h10,   32'hDEADBEEF, 0, 32'h0,        1'b0);
    tv[1] = mk(4'h0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 1'b0);
    tv[2] = mk(4'hF, 32'h20,   32'h11223344, 0, 32'h0,        1'b0);
    tv[3] = mk(4'h2, 32'h20,   32'h0000AB00, 0, 32'h0,        1'b0);
    tv[4] = mk(4'hC, 32'h20,   32'h55660000, 0, 32'h0,        1'b0);
    tv[5] = mk(4'h0, 32'h22,   32'h0,        1, 32'h5566AB44, 1'b0);
    tv[6] = mk(4'hF, 32'h4,    32'hA5A5A5A5, 0, 32'h0,        1'b0);
    tv[7] = mk(4'hF, 32'h1004, 32'h12345678, 0, 32'h0,        RC);
    tv[8] = mk(4'h0, 32'h4,    32'h0,        1, RC ? 32'hA5A5A5A5 : 32'h12345678, 1'b0);
    tv[9] = mk(4'h0, 32'h1004, 32'h0,        1, RC ? 32'h0 : 32'h12345678, RC);

    rst = 1'b1; req = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_addr_ok", 32'(addr_ok), 32'd1);
    check("reset_data_ok", 32'(data_ok), 32'd0);
    check("reset_rdata",   rdata,        32'd0);
    check("reset_err",     32'(err),     32'd0);

    for (int i = 0; i < 10; i++) begin
      do_req(tv[i].wen, tv[i].addr, tv[i].wdata, rd, e);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].exp_err));
      if (tv[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), 32'(data_ok), 32'd0);
    end

    // Back-to-back reads with req held high.
    do_req(4'hF, 32'h0, 32'h0BAD0000, rd, e);
    do_req(4'hF, 32'h8, 32'h0BAD0008, rd, e);
    @(negedge clk);
    hs = 0; pulses = 0; c = 0;
    req = 1'b1; wen = 4'h0; addr = 32'h0;
    while (pulses < 3 && c < 60) begin
      if (data_ok) begin
        pt[pulses] = c; prd[pulses] = rdata; pulses++;
      end
      take = req && addr_ok;
      if (take) begin
        ht[hs] = c; hs++;
      end
      @(posedge clk);
      #1;
      if (take) begin
        if (hs == 3) req = 1'b0;
        else addr = 32'(hs * 4);
      end
      @(negedge clk);
      c++;
    end
    check("b2b_handshakes", 32'(hs), 32'd3);
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_accept_gap", 32'(ht[1] - ht[0]), 32'(LAT));
    check("b2b_gap1", 32'(pt[1] - pt[0]), 32'(LAT));
    check("b2b_gap2", 32'(pt[2] - pt[1]), 32'(LAT));
    check("b2b_rd0", prd[0], 32'h0BAD0000);
    check("b2b_rd1", prd[1], RC ? 32'hA5A5A5A5 : 32'h12345678);
    check("b2b_rd2", prd[2], 32'h0BAD0008);

    // Reset while a write is pending.
    do_req(4'hF, 32'h30, 32'h01020304, rd, e);
    req = 1'b1; wen = 4'hF; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      if (data_ok) seen++;
      @(negedge clk);
    end
    check("rst_no_resp", 32'(seen), 32'd0);
    check("rst_addr_ok", 32'(addr_ok), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    do_req(4'h0, 32'h30, 32'h0, rd, e);
    check("rst_write_dropped", rd, 32'h01020304);

    // Randomized traffic over a preloaded window of 64 words.
    for (int i = 0; i < 64; i++) model_req(4'hF, 32'(i * 4), $urandom);
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  rw;
      logic [31:0] ra;
      rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ra = {($urandom_range(0, 7) == 0) ? 20'($urandom_range(1, 7)) : 20'd0,
            4'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
      model_req(rw, ra, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
